man_alu_pipe: RTL and testbench

Pipelined, parametrised mantissa adder/subtractor for the FPU add/sub datapath. It sits between exponent alignment and normalisation. It resolves the effective operation from the opcode and operand signs, then adds or subtracts the aligned mantissas with sticky-borrow handling. It also pre-computes the leading-zero count the normaliser needs. Two registered stages with valid/ready flow control replace the purely combinational predecessor.

---
 rtl/fpu_pkg.sv | 11 +
 rtl/man_lzc.sv | 37 +++
 rtl/man_alu_pipe.sv | 133 +++++++++++++
 tb/tb_man_alu_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Holds the opcode encodings and the default mantissa width (hidden bit
// included) used by the add/sub datapath blocks.
package fpu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int SIZE_MAN_DEF = 24;

endpackage

// File: rtl/man_lzc.sv
// Parametrised combinational leading-zero counter.
// Used after the mantissa adder and by the normaliser.
// Ports:
//   i_data       - vector to scan, MSB first
//   i_force_zero - forces the count to 0 and clears the all-zero flag
//                  (a carry-out sits above the vector)
//   o_count      - leading zeros of i_data; WIDTH when i_data is all zero
//   o_all_zero   - i_data is zero and no force
module man_lzc #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_force_zero,
  output logic [CNT_W-1:0] o_count,
  output logic             o_all_zero
);

  logic [CNT_W-1:0] w_cnt;
  logic             w_found;

  // The first set bit from the MSB wins; later hits are masked by w_found.
  always_comb begin
    w_cnt   = CNT_W'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        w_cnt   = CNT_W'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  assign o_count    = i_force_zero ? '0 : w_cnt;
  assign o_all_zero = ~w_found & ~i_force_zero;

endmodule

// File: rtl/man_alu_pipe.sv
// Two-stage pipelined mantissa adder/subtractor for the FPU add/sub path.
// It sits between exponent alignment and normalisation.
//   S1 - resolves the effective operation and registers sum/ovf/eff_sub.
//   S2 - registers S1 fields plus the leading-zero count and zero flag.
// Ports:
//   i_clk, i_rst_n        - clock, async active-low reset
//   i_valid / o_ready     - operand handshake
//   i_fpu_op, i_sign_a/b  - opcode and operand signs
//   i_carry               - sticky bit shifted out of i_man_min
//   i_man_max, i_man_min  - aligned mantissas (max has larger magnitude)
//   o_valid / i_ready     - result handshake
//   o_man_alu, o_overflow, o_eff_sub, o_lzc, o_zero - result fields
module man_alu_pipe
  import fpu_pkg::*;
#(
  parameter int SIZE_MAN = SIZE_MAN_DEF,
  parameter int LZC_W    = $clog2(SIZE_MAN + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_fpu_op,
  input  logic                i_sign_a,
  input  logic                i_sign_b,
  input  logic                i_carry,
  input  logic [SIZE_MAN-1:0] i_man_max,
  input  logic [SIZE_MAN-1:0] i_man_min,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man_alu,
  output logic                o_overflow,
  output logic                o_eff_sub,
  output logic [LZC_W-1:0]    o_lzc,
  output logic                o_zero
);

  logic                w_eff_op;
  logic                w_eff_sub;
  logic [SIZE_MAN:0]   w_full;
  logic [SIZE_MAN-1:0] w_sum;
  logic                w_ovf;
  logic                w_adv1;
  logic                w_adv2;
  logic [LZC_W-1:0]    w_lzc;
  logic                w_zero;

  logic                r_v1;
  logic [SIZE_MAN-1:0] r_sum1;
  logic                r_ovf1;
  logic                r_eff1;

  logic                r_v2;
  logic [SIZE_MAN-1:0] r_man2;
  logic                r_ovf2;
  logic                r_eff2;
  logic [LZC_W-1:0]    r_lzc2;
  logic                r_zero2;

  // Subtract is max + ~min + 1; a set sticky bit means a borrow was already
  // taken from the discarded bits, so the +1 is dropped.
  always_comb begin
    w_eff_op  = i_fpu_op ^ i_sign_a ^ i_sign_b;
    w_eff_sub = (w_eff_op == OP_SUB);
    if (w_eff_op == OP_ADD) begin
      w_full = {1'b0, i_man_max} + {1'b0, i_man_min};
    end else begin
      w_full = {1'b0, i_man_max} + {1'b0, ~i_man_min}
             + {{SIZE_MAN{1'b0}}, ~i_carry};
    end
    w_sum = w_full[SIZE_MAN-1:0];
    // The top bit of a subtract is the wrap of the two's complement, not a carry.
    w_ovf = w_full[SIZE_MAN] & ~w_eff_sub;
  end

  assign w_adv2  = ~r_v2 | i_ready;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign o_ready = w_adv1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1   <= 1'b0;
      r_sum1 <= '0;
      r_ovf1 <= 1'b0;
      r_eff1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_sum1 <= w_sum;
        r_ovf1 <= w_ovf;
        r_eff1 <= w_eff_sub;
      end
    end
  end

  man_lzc #(
    .WIDTH (SIZE_MAN),
    .CNT_W (LZC_W)
  ) u_lzc (
    .i_data       (r_sum1),
    .i_force_zero (r_ovf1),
    .o_count      (w_lzc),
    .o_all_zero   (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2    <= 1'b0;
      r_man2  <= '0;
      r_ovf2  <= 1'b0;
      r_eff2  <= 1'b0;
      r_lzc2  <= '0;
      r_zero2 <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_man2  <= r_sum1;
        r_ovf2  <= r_ovf1;
        r_eff2  <= r_eff1;
        r_lzc2  <= w_lzc;
        r_zero2 <= w_zero;
      end
    end
  end

  assign o_valid    = r_v2;
  assign o_man_alu  = r_man2;
  assign o_overflow = r_ovf2;
  assign o_eff_sub  = r_eff2;
  assign o_lzc      = r_lzc2;
  assign o_zero     = r_zero2;

endmodule

// File: tb/tb_man_alu_pipe.sv
// Scoreboard bench for man_alu_pipe (SIZE_MAN = 24).
// The driver pushes expected results when an operand is accepted. The
// negedge monitor pops and compares whenever a result transfers.
module tb_man_alu_pipe;

  localparam int SM = 24;
  localparam int LW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_fpu_op = 1'b0;
  logic          i_sign_a = 1'b0;
  logic          i_sign_b = 1'b0;
  logic          i_carry = 1'b0;
  logic          i_ready = 1'b1;
  logic [SM-1:0] i_man_max = '0;
  logic [SM-1:0] i_man_min = '0;
  logic          o_ready;
  logic          o_valid;
  logic [SM-1:0] o_man_alu;
  logic          o_overflow;
  logic          o_eff_sub;
  logic [LW-1:0] o_lzc;
  logic          o_zero;

  man_alu_pipe #(.SIZE_MAN(SM), .LZC_W(LW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_fpu_op   (i_fpu_op),
    .i_sign_a   (i_sign_a),
    .i_sign_b   (i_sign_b),
    .i_carry    (i_carry),
    .i_man_max  (i_man_max),
    .i_man_min  (i_man_min),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_man_alu  (o_man_alu),
    .o_overflow (o_overflow),
    .o_eff_sub  (o_eff_sub),
    .o_lzc      (o_lzc),
    .o_zero     (o_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [SM-1:0] man;
    logic          ovf;
    logic          eff;
    logic [LW-1:0] lzc;
    logic          zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  exp_t mon_e;
  exp_t mon_got;
  exp_t held;
  logic held_ok = 1'b0;
  logic saw_stall_ready = 1'b0;
  logic rand_done = 1'b0;

  // Reference model: plain integer arithmetic on magnitudes.
  function automatic exp_t model(input logic op, input logic sa, input logic sb,
                                 input logic c, input logic [SM-1:0] mx,
                                 input logic [SM-1:0] mn);
    exp_t   e;
    longint s;
    longint v;
    int     n;
    e.eff = op ^ sa ^ sb;
    if (e.eff) begin
      s = longint'(mx) - longint'(mn) - longint'(c);
      if (s < 0) s += 64'sd16777216;
      e.ovf = 1'b0;
    end else begin
      s = longint'(mx) + longint'(mn);
      e.ovf = (s >= 64'sd16777216);
      if (e.ovf) s -= 64'sd16777216;
    end
    e.man = s[SM-1:0];
    n = 0;
    v = s;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    e.lzc  = e.ovf ? '0 : LW'(SM - n);
    e.zero = (s == 0) && !e.ovf;
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      mon_got = {o_man_alu, o_overflow, o_eff_sub, o_lzc, o_zero};
      checks++;
      if (o_ready !== ((exp_q.size() < 2) || i_ready)) begin
        failures++;
        $display("FAIL o_ready got=%b exp=%b (in flight %0d, i_ready %b)",
                 o_ready, ((exp_q.size() < 2) || i_ready), exp_q.size(), i_ready);
      end
      if (o_valid && !i_ready && !o_ready) saw_stall_ready = 1'b1;
      if (o_valid && !i_ready) begin
        if (held_ok) begin
          checks++;
          if (mon_got !== held) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", mon_got, held);
          end
        end
        held    = mon_got;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got man=%h ovf=%b", o_man_alu, o_overflow);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_got !== mon_e) begin
            failures++;
            $display("FAIL result got man=%h ovf=%b eff=%b lzc=%0d zero=%b exp man=%h ovf=%b eff=%b lzc=%0d zero=%b",
                     mon_got.man, mon_got.ovf, mon_got.eff, mon_got.lzc, mon_got.zero,
                     mon_e.man, mon_e.ovf, mon_e.eff, mon_e.lzc, mon_e.zero);
          end
        end
      end
    end else begin
      held_ok = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_e(input logic op, input logic sa, input logic sb, input logic c,
                        input logic [SM-1:0] mx, input logic [SM-1:0] mn, input exp_t e);
    logic acc;
    i_valid   = 1'b1;
    i_fpu_op  = op;
    i_sign_a  = sa;
    i_sign_b  = sb;
    i_carry   = c;
    i_man_max = mx;
    i_man_min = mn;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      if (acc) begin
        exp_q.push_back(e);
        #1;
        i_valid = 1'b0;
        return;
      end
      #1;
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout o_ready=%b exp=1", o_ready);
    i_valid = 1'b0;
  endtask

  task automatic send(input logic op, input logic sa, input logic sb, input logic c,
                      input logic [SM-1:0] mx, input logic [SM-1:0] mn);
    send_e(op, sa, sb, c, mx, mn, model(op, sa, sb, c, mx, mn));
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) return;
      @(posedge i_clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Send one operand into an empty pipe and confirm it shows after two edges.
  task automatic latency_probe(input logic [SM-1:0] mx, input logic [SM-1:0] mn);
    send(1'b0, 1'b0, 1'b0, 1'b0, mx, mn);
    chk("lat_edge1_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    chk("lat_edge2_valid", 32'(o_valid), 32'd1);
    drain();
  endtask

  task automatic rand_op();
    logic [SM-1:0] mx;
    logic [SM-1:0] mn;
    int            k;
    mx = SM'($urandom);
    k  = int'($urandom_range(0, 3));
    case (k)
      0:       mn = mx;
      1:       mn = mx >> $urandom_range(0, SM);
      2:       mn = mx - 1'b1;
      default: mn = SM'($urandom);
    endcase
    send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mx, mn);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_man", 32'(o_man_alu), 32'd0);
    chk("rst_flags", {28'd0, o_overflow, o_eff_sub, o_zero, 1'b0}, 32'd0);
    chk("rst_lzc", 32'(o_lzc), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    // Directed vectors with hand-computed results.
    send_e(1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 24'h800000, '{24'h000000, 1'b1, 1'b0, 5'd0, 1'b0});
    send_e(1'b1, 1'b0, 1'b0, 1'b0, 24'hC00000, 24'h400000, '{24'h800000, 1'b0, 1'b1, 5'd0, 1'b0});
    send_e(1'b1, 1'b0, 1'b0, 1'b1, 24'h800000, 24'h400000, '{24'h3FFFFF, 1'b0, 1'b1, 5'd2, 1'b0});
    send_e(1'b0, 1'b0, 1'b1, 1'b0, 24'h800000, 24'h800000, '{24'h000000, 1'b0, 1'b1, 5'd24, 1'b1});
    send_e(1'b0, 1'b0, 1'b1, 1'b0, 24'h800000, 24'h7FFFFF, '{24'h000001, 1'b0, 1'b1, 5'd23, 1'b0});
    send_e(1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'h000001, '{24'h000000, 1'b1, 1'b0, 5'd0, 1'b0});
    drain();
    latency_probe(24'h123456, 24'h000111);

    // Back-pressure: five operands, i_ready low for three cycles mid-stream.
    saw_stall_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) rand_op();
      end
      begin
        repeat (2) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_dropped", 32'(saw_stall_ready), 32'd1);

    // Reset with both stages full.
    i_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 1'b0, 24'h400000, 24'h200000);
    send(1'b1, 1'b0, 1'b0, 1'b0, 24'h400000, 24'h000001);
    chk("full_valid", 32'(o_valid), 32'd1);
    chk("full_ready", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_man", 32'(o_man_alu), 32'd0);
    chk("midrst_flags", {29'd0, o_overflow, o_eff_sub, o_zero}, 32'd0);
    chk("midrst_lzc", 32'(o_lzc), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("relrst_ready", 32'(o_ready), 32'd1);
    latency_probe(24'h000F00, 24'h0000F0);

    // Random traffic with random back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) rand_op();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    i_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
